// File: rtl/shift_req_fifo_if.sv
// Request/response handshake bundle for shift_req_fifo.
// The master modport belongs to the producer/consumer side; the slave modport belongs to the FIFO.
interface shift_req_fifo_if #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SHIFT_WIDTH = 5,
  parameter int unsigned AMT_WIDTH   = 8,
  parameter int unsigned DEPTH       = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [AMT_WIDTH-1:0]   in_amt;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_A;
  logic [SHIFT_WIDTH-1:0] out_B;
  logic [CW-1:0]          count;

  modport master (
    output in_valid, in_data, in_amt, out_ready,
    input  in_ready, out_valid, out_A, out_B, count
  );

  modport slave (
    input  in_valid, in_data, in_amt, out_ready,
    output in_ready, out_valid, out_A, out_B, count
  );
endinterface

// File: rtl/shift_req_fifo.sv
// Request-staging FIFO ahead of the left shifter: buffers {operand, amount} pairs and presents the head as registered operands.
// Optional macro SHIFT_REQ_CLAMP_EN: when in_amt >= WIDTH, the request is stored as operand 0 and amount 0.
module shift_req_fifo #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SHIFT_WIDTH = 5,
  parameter int unsigned AMT_WIDTH   = 8,
  parameter int unsigned DEPTH       = 4
) (
  input logic            clk,
  input logic            rst_n,
  shift_req_fifo_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_e;

  occ_e                   state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]       out_a_q, out_a_d;
  logic [SHIFT_WIDTH-1:0] out_b_q, out_b_d;

  logic [WIDTH-1:0]       mem_a_q [DEPTH];
  logic [SHIFT_WIDTH-1:0] mem_b_q [DEPTH];

  logic                   in_ready;
  logic                   out_valid;
  logic                   push;
  logic                   pop;
  logic [WIDTH-1:0]       wdata_a;
  logic [SHIFT_WIDTH-1:0] wdata_b;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_A     = out_a_q;
  assign bus.out_B     = out_b_q;
  assign bus.count     = count_q;

  // Amount reduction happens once, at push; the reduced value is what gets stored.
  always_comb begin
`ifdef SHIFT_REQ_CLAMP_EN
    if (32'(bus.in_amt) >= 32'(WIDTH)) begin
      wdata_a = '0;
      wdata_b = '0;
    end else begin
      wdata_a = bus.in_data;
      wdata_b = bus.in_amt[SHIFT_WIDTH-1:0];
    end
`else
    wdata_a = bus.in_data;
    wdata_b = bus.in_amt[SHIFT_WIDTH-1:0];
`endif
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (count_d == '0)             state_d = EMPTY;
    else if (count_d == CW'(DEPTH)) state_d = FULL;
    else                           state_d = PARTIAL;

    // Next head lives at rd_ptr_d; if that slot is being written this cycle the
    // memory still holds stale data, so take the incoming request instead.
    if (state_d == EMPTY) begin
      out_a_d = '0;
      out_b_d = '0;
    end else if (push && (wr_ptr_q == rd_ptr_d)) begin
      out_a_d = wdata_a;
      out_b_d = wdata_b;
    end else begin
      out_a_d = mem_a_q[rd_ptr_d];
      out_b_d = mem_b_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      out_a_q  <= '0;
      out_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      out_a_q  <= out_a_d;
      out_b_q  <= out_b_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= wdata_a;
      mem_b_q[wr_ptr_q] <= wdata_b;
    end
  end
endmodule

// File: tb/tb_shift_req_fifo.sv
// Directed bench for shift_req_fifo: a vector table plus reset, streaming and async-reset sequences.
module tb_shift_req_fifo;
  localparam int unsigned WIDTH       = 32;
  localparam int unsigned SHIFT_WIDTH = 5;
  localparam int unsigned AMT_WIDTH   = 8;
  localparam int unsigned DEPTH       = 4;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  shift_req_fifo_if #(
    .WIDTH(WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH), .AMT_WIDTH(AMT_WIDTH), .DEPTH(DEPTH)
  ) bus_if ();

  shift_req_fifo #(
    .WIDTH(WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH), .AMT_WIDTH(AMT_WIDTH), .DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        iv;
    logic [31:0] data;
    logic [7:0]  amt;
    logic        ordy;
    logic        ev;
    logic [31:0] ea;
    logic [4:0]  eb;
    logic [2:0]  ecnt;
    logic        erdy;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [31:0] ea,
                           input logic [4:0] eb, input logic [2:0] ecnt, input logic erdy);
    check({tag, ".out_valid"}, 64'(bus_if.out_valid), 64'(ev));
    check({tag, ".out_A"},     64'(bus_if.out_A),     64'(ea));
    check({tag, ".out_B"},     64'(bus_if.out_B),     64'(eb));
    check({tag, ".count"},     64'(bus_if.count),     64'(ecnt));
    check({tag, ".in_ready"},  64'(bus_if.in_ready),  64'(erdy));
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic [7:0] a, input logic ordy);
    bus_if.in_valid  = iv;
    bus_if.in_data   = d;
    bus_if.in_amt    = a;
    bus_if.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a37;
    logic [4:0]  b37;
    logic [31:0] a200;
    logic [4:0]  b200;
    pass_cnt  = 0;
    total_cnt = 0;

`ifdef SHIFT_REQ_CLAMP_EN
    a37 = 32'h0; b37 = 5'd0; a200 = 32'h0; b200 = 5'd0;
`else
    a37 = 32'hFFFF_FFFF; b37 = 5'd5; a200 = 32'h9; b200 = 5'd8;
`endif

    //          iv  data          amt     ordy  ev  eA            eB     cnt   rdy
    vecs[0]  = '{1'b1, 32'h0000_00F1, 8'd4,   1'b0, 1'b1, 32'h0000_00F1, 5'd4,  3'd1, 1'b1};
    vecs[1]  = '{1'b0, 32'h0,         8'd0,   1'b1, 1'b0, 32'h0,         5'd0,  3'd0, 1'b1};
    vecs[2]  = '{1'b1, 32'h1,         8'd1,   1'b0, 1'b1, 32'h1,         5'd1,  3'd1, 1'b1};
    vecs[3]  = '{1'b1, 32'h2,         8'd2,   1'b0, 1'b1, 32'h1,         5'd1,  3'd2, 1'b1};
    vecs[4]  = '{1'b1, 32'h3,         8'd3,   1'b0, 1'b1, 32'h1,         5'd1,  3'd3, 1'b1};
    vecs[5]  = '{1'b1, 32'h4,         8'd4,   1'b0, 1'b1, 32'h1,         5'd1,  3'd4, 1'b0};
    vecs[6]  = '{1'b1, 32'h5,         8'd5,   1'b0, 1'b1, 32'h1,         5'd1,  3'd4, 1'b0};
    vecs[7]  = '{1'b1, 32'h6,         8'd6,   1'b1, 1'b1, 32'h2,         5'd2,  3'd3, 1'b1};
    vecs[8]  = '{1'b0, 32'h0,         8'd0,   1'b1, 1'b1, 32'h3,         5'd3,  3'd2, 1'b1};
    vecs[9]  = '{1'b0, 32'h0,         8'd0,   1'b1, 1'b1, 32'h4,         5'd4,  3'd1, 1'b1};
    vecs[10] = '{1'b0, 32'h0,         8'd0,   1'b1, 1'b0, 32'h0,         5'd0,  3'd0, 1'b1};
    vecs[11] = '{1'b1, 32'hFFFF_FFFF, 8'd37,  1'b0, 1'b1, a37,           b37,   3'd1, 1'b1};
    vecs[12] = '{1'b1, 32'h7,         8'd31,  1'b1, 1'b1, 32'h7,         5'd31, 3'd1, 1'b1};
    vecs[13] = '{1'b0, 32'h0,         8'd0,   1'b1, 1'b0, 32'h0,         5'd0,  3'd0, 1'b1};
    vecs[14] = '{1'b0, 32'h0,         8'd0,   1'b1, 1'b0, 32'h0,         5'd0,  3'd0, 1'b1};
    vecs[15] = '{1'b1, 32'h9,         8'd200, 1'b1, 1'b1, a200,          b200,  3'd1, 1'b1};
    vecs[16] = '{1'b1, 32'hA,         8'd32,  1'b0, 1'b1, a200,          b200,  3'd2, 1'b1};
    vecs[17] = '{1'b0, 32'h0,         8'd0,   1'b1, 1'b1, 32'hA,         5'd0,  3'd1, 1'b1};
`ifdef SHIFT_REQ_CLAMP_EN
    vecs[17].ea = 32'h0;
`endif

    // Reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), $urandom, 8'($urandom), 1'($urandom));
      tick();
    end
    check_all("reset", 1'b0, 32'h0, 5'd0, 3'd0, 1'b1);

    drive(1'b0, 32'h0, 8'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].iv, vecs[i].data, vecs[i].amt, vecs[i].ordy);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ea, vecs[i].eb, vecs[i].ecnt, vecs[i].erdy);
    end
    drive(1'b0, 32'h0, 8'd0, 1'b1);
    tick();
    check("drain_empty.count", 64'(bus_if.count), 64'd0);

    // Steady stream: one in, one out per cycle
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'(i), 8'(i), 1'b1);
      tick();
      check($sformatf("stream%0d.count", i), 64'(bus_if.count), 64'd1);
      check($sformatf("stream%0d.out_A", i), 64'(bus_if.out_A), 64'(i));
      check($sformatf("stream%0d.out_B", i), 64'(bus_if.out_B), 64'(i % 32));
    end
    drive(1'b0, 32'h0, 8'd0, 1'b1);
    tick();
    check_all("stream_end", 1'b0, 32'h0, 5'd0, 3'd0, 1'b1);

    // Async reset with three entries buffered
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(16 + i), 8'd1, 1'b0);
      tick();
    end
    check("prereset.count", 64'(bus_if.count), 64'd3);
    drive(1'b0, 32'h0, 8'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.count", 64'(bus_if.count), 64'd0);
    check("async_rst.out_valid", 64'(bus_if.out_valid), 64'd0);
    check("async_rst.out_A", 64'(bus_if.out_A), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h55, 8'd3, 1'b0);
    tick();
    check_all("post_rst", 1'b1, 32'h55, 5'd3, 3'd1, 1'b1);
    drive(1'b0, 32'h0, 8'd0, 1'b1);
    tick();
    check_all("post_rst_pop", 1'b0, 32'h0, 5'd0, 3'd0, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
